dac_i2s_sink: RTL and testbench
===============================

// Module: dac_i2s_sink
// PURPOSE
// Consumer end of the DAC bus. It takes the stereo samples and timing strobes produced by the
//  mapper-side DAC controller (dac_clk tick, 9-bit phase, next_sample).
// It serialises each sample frame onto an I2S link (bck/lrck/sdo) for the board audio DAC.
// It applies a soft-mute gain ramp driven by snd_on, and mutes on phase discontinuity.
// PARAMETERS
// RAMP_STEP    1    gain change per latched sample; gain range 0..256 (256 = unity)
// DESYNC_MUTE  1    1: phase discontinuity forces the gain ramp down; 0: flag only
// PORTS
// clk          in   1    system clock; sole clock domain
// rst          in   1    synchronous reset, active-low (0 = reset)
// dac_clk      in   1    one-clk tick; every other input is sampled only when this is 1
// next_sample  in   1    tick qualifier; 1 when dac_clk=1 and phase=511
// phase        in   9    position in the 512-tick sample frame
// snd_on       in   1    1 = audio enabled (ramp gain up), 0 = ramp down
// snd_l        in   16   signed left sample
// snd_r        in   16   signed right sample
// dac_bck      out  1    I2S bit clock; 8 ticks per period
// dac_lrck     out  1    I2S word select; 0 = left, 1 = right
// dac_sdo      out  1    I2S serial data, MSB first, delayed one bck after the lrck edge
// muted        out  1    1 when gain = 0
// desync       out  1    sticky phase-discontinuity flag; cleared by a clean frame
// BEHAVIOUR
// - Reset (rst=0 at a clk edge) forces: dac_bck=0, dac_lrck=0, dac_sdo=0, gain=0, muted=1,
//   desync=0, hold_l=hold_r=0, prev_phase=511. Reset mid-frame aborts the frame.
//   Output stays 0 until the first latch after reset.
// - All state advances only on clk edges with dac_clk=1. Cycles with dac_clk=0 hold all state.
// - Latch on next_sample:
//   - Compute hold_x <= (snd_x * gain) >>> 8 as a signed 16x9 product, keeping bits [23:8].
//     gain=256 yields exactly snd_x. Arithmetic-shift rounding (toward -inf).
//   - The latch uses the gain value before this tick's update.
//   - Gain update on the same tick:
//     - up when snd_on=1 and !(desync & DESYNC_MUTE): gain <= min(gain+RAMP_STEP, 256)
//     - otherwise: gain <= max(gain-RAMP_STEP, 0)
//   - snd_on changes mid-frame take effect at the next latch only.
// - Serialiser (registered, one-tick latency from phase):
//   - dac_bck <= phase[2]
//   - dac_lrck <= phase[8]
//   - Word slot s = phase[7:3] (0..31). Word = hold_l when phase[8]=0, else hold_r.
//   - When phase[2:0]=0 (bck falling): dac_sdo <= word[16-s] for s in 1..16, else 0.
//     Slot 0 and slots 17..31 carry 0.
//   - The frame at phases 0..511 serialises the samples latched at the preceding phase 511.
// - Desync:
//   - On each tick, if phase != prev_phase+1 (mod 512), set desync. prev_phase <= phase.
//   - On a next_sample tick with no discontinuity since the previous latch, clear desync.
//   - A discontinuity on the next_sample tick itself keeps desync=1 (set wins).
// - muted is registered: muted <= (gain_next == 0).
// TESTING
// 1. Reset with dac_clk idle -> all outputs 0 except muted=1.
//    Hold 10 clk with dac_clk=0 -> no output change.
// 2. snd_on=1, snd_l=16'h7FFF, contiguous phase, RAMP_STEP=1. The 129th latch uses gain=128,
//    so hold_l=16'h3FFF, and left slots 1..16 shift out 0,0,1,1,...,1.
// 3. Run 300 frames with snd_on=1 -> gain saturates at 256, no overflow.
//    snd_l=16'h8000 serialises as 1 followed by fifteen 0s. snd_r=16'h4000 gives sdo=0,1,0,...
// 4. Drop snd_on to 0 at gain=256 -> muted=1 after exactly 256 further latches.
//    Gain never wraps below 0.
// 5. Inject a phase jump 100->300 -> desync=1 next clk and gain ramps down (DESYNC_MUTE=1).
//    The next clean frame clears desync at its phase-511 tick.
// 6. Assert rst=0 at phase 200 mid-frame -> outputs zero next clk.
//    After release, zeros are shifted until the first latch.
//    Check lrck/bck timing: bck period 8 ticks, lrck toggles at phase 256 and phase 0.

Source files
------------

// File: rtl/dac_i2s_sink.sv
// Consumer end of the DAC bus: latches stereo samples through a soft-mute gain ramp
// and serialises them onto an I2S link (bck/lrck/sdo), flagging phase discontinuities.
module dac_i2s_sink #(
  parameter int unsigned RAMP_STEP   = 32'd1,
  parameter bit          DESYNC_MUTE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dac_clk,
  input  logic        next_sample,
  input  logic [8:0]  phase,
  input  logic        snd_on,
  input  logic [15:0] snd_l,
  input  logic [15:0] snd_r,
  output logic        dac_bck,
  output logic        dac_lrck,
  output logic        dac_sdo,
  output logic        muted,
  output logic        desync
);

  localparam logic [9:0] STEP_W     = 10'(RAMP_STEP);
  localparam logic [8:0] GAIN_UNITY = 9'd256;

  logic [8:0]  gain_r;
  logic [15:0] hold_l_r;
  logic [15:0] hold_r_r;
  logic [8:0]  prev_phase_r;
  logic        seen_r;
  logic        desync_r;
  logic        bck_r;
  logic        lrck_r;
  logic        sdo_r;
  logic        muted_r;

  logic [8:0]         phase_inc_s;
  logic               disc_s;
  logic               latch_s;
  logic               ramp_up_s;
  logic [9:0]         gain_x_s;
  logic [9:0]         up_sum_s;
  logic [9:0]         dn_diff_s;
  logic [8:0]         gain_up_s;
  logic [8:0]         gain_dn_s;
  logic [8:0]         gain_next_s;
  logic signed [25:0] snd_l_x_s;
  logic signed [25:0] snd_r_x_s;
  logic signed [25:0] gain_mul_s;
  logic signed [25:0] prod_l_s;
  logic signed [25:0] prod_r_s;
  logic [4:0]         slot_s;
  logic [4:0]         bit_idx_s;
  logic [15:0]        word_s;
  logic               sdo_bit_s;

  // Signed 16x10 products; bits [23:8] give the arithmetic >>> 8 of the scaled sample.
  assign snd_l_x_s  = {{10{snd_l[15]}}, snd_l};
  assign snd_r_x_s  = {{10{snd_r[15]}}, snd_r};
  assign gain_mul_s = {17'd0, gain_r};
  assign prod_l_s   = snd_l_x_s * gain_mul_s;
  assign prod_r_s   = snd_r_x_s * gain_mul_s;

  // Tick decode, discontinuity detection and saturating gain ramp.
  always_comb begin
    phase_inc_s = prev_phase_r + 9'd1;
    latch_s     = dac_clk & next_sample;
    ramp_up_s   = snd_on & ~(desync_r & DESYNC_MUTE);
    gain_x_s    = {1'b0, gain_r};
    up_sum_s    = gain_x_s + STEP_W;
    dn_diff_s   = gain_x_s - STEP_W;
    disc_s      = 1'b0;
    gain_up_s   = GAIN_UNITY;
    gain_dn_s   = 9'd0;
    gain_next_s = gain_r;
    if (dac_clk) begin
      disc_s = (phase != phase_inc_s);
    end else begin
      disc_s = 1'b0;
    end
    if (up_sum_s > {1'b0, GAIN_UNITY}) begin
      gain_up_s = GAIN_UNITY;
    end else begin
      gain_up_s = up_sum_s[8:0];
    end
    if (gain_x_s > STEP_W) begin
      gain_dn_s = dn_diff_s[8:0];
    end else begin
      gain_dn_s = 9'd0;
    end
    if (latch_s) begin
      if (ramp_up_s) begin
        gain_next_s = gain_up_s;
      end else begin
        gain_next_s = gain_dn_s;
      end
    end else begin
      gain_next_s = gain_r;
    end
  end

  // Serial bit selection: slot 1 carries the MSB, slot 0 and slots 17..31 are padding.
  always_comb begin
    slot_s    = phase[7:3];
    bit_idx_s = 5'd16 - slot_s;
    word_s    = hold_l_r;
    sdo_bit_s = 1'b0;
    if (phase[8]) begin
      word_s = hold_r_r;
    end else begin
      word_s = hold_l_r;
    end
    if ((slot_s != 5'd0) && (slot_s <= 5'd16)) begin
      sdo_bit_s = word_s[bit_idx_s[3:0]];
    end else begin
      sdo_bit_s = 1'b0;
    end
  end

  // State register; nothing moves unless dac_clk ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gain_r       <= 9'd0;
      hold_l_r     <= 16'd0;
      hold_r_r     <= 16'd0;
      prev_phase_r <= 9'd511;
      seen_r       <= 1'b0;
      desync_r     <= 1'b0;
      bck_r        <= 1'b0;
      lrck_r       <= 1'b0;
      sdo_r        <= 1'b0;
      muted_r      <= 1'b1;
    end else if (dac_clk) begin
      prev_phase_r <= phase;
      bck_r        <= phase[2];
      lrck_r       <= phase[8];
      gain_r       <= gain_next_s;
      muted_r      <= (gain_next_s == 9'd0);
      if (phase[2:0] == 3'd0) begin
        sdo_r <= sdo_bit_s;
      end
      if (next_sample) begin
        hold_l_r <= prod_l_s[23:8];
        hold_r_r <= prod_r_s[23:8];
        desync_r <= disc_s | seen_r;
        seen_r   <= 1'b0;
      end else begin
        desync_r <= desync_r | disc_s;
        seen_r   <= seen_r | disc_s;
      end
    end
  end

  assign dac_bck  = bck_r;
  assign dac_lrck = lrck_r;
  assign dac_sdo  = sdo_r;
  assign muted    = muted_r;
  assign desync   = desync_r;

endmodule

// File: tb/tb_dac_i2s_sink.sv
// Self-checking bench for dac_i2s_sink: constant vector table for the gain ramp,
// hand-written desync/reset sequences, and randomized frames against a frame-level model.
module tb_dac_i2s_sink;

  localparam int STEP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        dac_clk;
  logic        next_sample;
  logic [8:0]  phase;
  logic        snd_on;
  logic [15:0] snd_l;
  logic [15:0] snd_r;
  logic        dac_bck;
  logic        dac_lrck;
  logic        dac_sdo;
  logic        muted;
  logic        desync;

  int tests_run    = 0;
  int tests_failed = 0;

  dac_i2s_sink #(.RAMP_STEP(32'd16), .DESYNC_MUTE(1'b1)) dut (
    .clk(clk), .rst(rst), .dac_clk(dac_clk), .next_sample(next_sample), .phase(phase),
    .snd_on(snd_on), .snd_l(snd_l), .snd_r(snd_r), .dac_bck(dac_bck), .dac_lrck(dac_lrck),
    .dac_sdo(dac_sdo), .muted(muted), .desync(desync)
  );

  always #5 clk = ~clk;

  // reference model state
  int          g_m;
  int          prev_m;
  logic [15:0] hl_m, hr_m;
  bit          desync_m, seen_m, muted_m, sdo_m, bck_m, lrck_m;

  // stimulus intent and per-frame observations
  logic [15:0] sl, sr;
  bit          son, gaps_en, flip_en;
  int          frame_err;
  string       first_err;
  logic [15:0] cap_l, cap_r;
  int          bck_rises, lrck_rise_ph, lrck_fall_ph;
  bit          last_bck, last_lrck;

  typedef struct {
    bit          on;
    logic [15:0] l, r, exp_l, exp_r;
    bit          exp_muted;
  } vec_t;
  vec_t vecs[37];

  function automatic logic [15:0] scale(input logic [15:0] x, input int g);
    int xs, prod, q;
    xs   = int'($signed(x));
    prod = xs * g;
    if (prod >= 0) q = prod / 256;
    else q = -((-prod + 255) / 256);
    return q[15:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    g_m = 0; prev_m = 511; hl_m = 16'h0000; hr_m = 16'h0000;
    desync_m = 1'b0; seen_m = 1'b0; muted_m = 1'b1;
    sdo_m = 1'b0; bck_m = 1'b0; lrck_m = 1'b0;
  endtask

  task automatic model_tick(input int p);
    bit disc;
    int s;
    logic [15:0] w;
    disc   = (p != (prev_m + 1) % 512);
    prev_m = p;
    bck_m  = p[2];
    lrck_m = p[8];
    if (p % 8 == 0) begin
      w = (p >= 256) ? hr_m : hl_m;
      s = (p % 256) / 8;
      sdo_m = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
    end
    if (p == 511) begin
      hl_m = scale(sl, g_m);
      hr_m = scale(sr, g_m);
      if (son && !desync_m) g_m = (g_m + STEP > 256) ? 256 : g_m + STEP;
      else g_m = (g_m - STEP < 0) ? 0 : g_m - STEP;
      desync_m = disc || seen_m;
      seen_m   = 1'b0;
    end else if (disc) begin
      desync_m = 1'b1;
      seen_m   = 1'b1;
    end
    muted_m = (g_m == 0);
  endtask

  task automatic cmp_tick(input int p);
    logic [4:0] act, exp;
    act = {dac_bck, dac_lrck, dac_sdo, muted, desync};
    exp = {bck_m, lrck_m, sdo_m, muted_m, desync_m};
    if (act !== exp) begin
      if (frame_err == 0)
        first_err = $sformatf("phase %0d got bck,lrck,sdo,muted,desync=%b expected %b", p, act, exp);
      frame_err++;
    end
  endtask

  task automatic capture(input int p);
    int s;
    if (p % 8 == 0) begin
      s = (p % 256) / 8;
      if (s >= 1 && s <= 16) begin
        if (p < 256) cap_l[16 - s] = dac_sdo;
        else cap_r[16 - s] = dac_sdo;
      end
    end
    if (dac_bck && !last_bck) bck_rises++;
    if (dac_lrck && !last_lrck) lrck_rise_ph = p;
    if (!dac_lrck && last_lrck) lrck_fall_ph = p;
    last_bck  = dac_bck;
    last_lrck = dac_lrck;
  endtask

  task automatic idle_clk();
    dac_clk = 1'b0;
    next_sample = 1'($urandom_range(0, 1));
    phase = 9'($urandom_range(0, 511));
    snd_on = 1'($urandom_range(0, 1));
    snd_l = 16'($urandom);
    snd_r = 16'($urandom);
    @(posedge clk); #1;
    cmp_tick(-1);
  endtask

  task automatic do_tick(input int p);
    if (gaps_en && $urandom_range(0, 7) == 0) idle_clk();
    if (flip_en && $urandom_range(0, 63) == 0) son = ~son;
    dac_clk = 1'b1; next_sample = (p == 511); phase = p[8:0];
    snd_on = son; snd_l = sl; snd_r = sr;
    @(posedge clk); #1;
    dac_clk = 1'b0;
    model_tick(p);
    cmp_tick(p);
    capture(p);
  endtask

  task automatic run_span(input int first, input int last);
    for (int p = first; p <= last; p++) do_tick(p);
  endtask

  task automatic frame_begin();
    frame_err = 0; first_err = ""; cap_l = 16'h0000; cap_r = 16'h0000;
    bck_rises = 0; lrck_rise_ph = -1; lrck_fall_ph = -1;
  endtask

  task automatic frame_end(input string name);
    tests_run++;
    if (frame_err != 0) begin
      tests_failed++;
      $display("FAIL %s stream: %0d mismatching clocks, first at %s", name, frame_err, first_err);
    end
  endtask

  task automatic full_frame(input string name);
    frame_begin();
    run_span(0, 511);
    frame_end(name);
  endtask

  initial begin
    logic [15:0] prev_l, prev_r;
    int a, b;

    for (int i = 0; i < 37; i++)
      vecs[i] = '{(i < 19), 16'h0000, 16'h0000, 16'h0000, 16'h0000, (i >= 34)};
    vecs[0]  = '{1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h7FFF, 16'h8000, 16'h07FF, 16'hF800, 1'b0};
    vecs[2]  = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h0FFF, 16'hFFFF, 1'b0};
    vecs[3]  = '{1'b1, 16'h0100, 16'hFF00, 16'h0030, 16'hFFD0, 1'b0};
    vecs[4]  = '{1'b1, 16'h7FFF, 16'h8000, 16'h1FFF, 16'hE000, 1'b0};
    vecs[5]  = '{1'b1, 16'h1234, 16'h0001, 16'h05B0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h2FFF, 16'hFFFF, 1'b0};
    vecs[7]  = '{1'b1, 16'h0000, 16'h8001, 16'h0000, 16'hC800, 1'b0};
    vecs[8]  = '{1'b1, 16'h7FFF, 16'h4000, 16'h3FFF, 16'h2000, 1'b0};
    vecs[12] = '{1'b1, 16'h7FFF, 16'h8000, 16'h5FFF, 16'hA000, 1'b0};
    vecs[16] = '{1'b1, 16'h8000, 16'h4000, 16'h8000, 16'h4000, 1'b0};
    vecs[17] = '{1'b1, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001, 1'b0};
    vecs[18] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0};
    vecs[19] = '{1'b0, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 1'b0};
    vecs[23] = '{1'b0, 16'h0100, 16'hFF00, 16'h00C0, 16'hFF40, 1'b0};
    vecs[27] = '{1'b0, 16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF, 1'b0};
    vecs[34] = '{1'b0, 16'h7FFF, 16'h8000, 16'h07FF, 16'hF800, 1'b1};
    vecs[35] = '{1'b0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b1};
    vecs[36] = '{1'b0, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1};

    gaps_en = 1'b0; flip_en = 1'b0; son = 1'b0; sl = 16'h0000; sr = 16'h0000;
    last_bck = 1'b0; last_lrck = 1'b0;
    model_reset();

    // reset with dac_clk idle, then hold
    rst = 1'b0; dac_clk = 1'b0; next_sample = 1'b0; phase = 9'd0;
    snd_on = 1'b0; snd_l = 16'h0000; snd_r = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bck", dac_bck, 0);
    check("rst_lrck", dac_lrck, 0);
    check("rst_sdo", dac_sdo, 0);
    check("rst_muted", muted, 1);
    check("rst_desync", desync, 0);
    rst = 1'b1;
    frame_begin();
    repeat (10) idle_clk();
    frame_end("idle_hold");

    // gain ramp up, saturation, ramp down to mute
    prev_l = 16'h0000; prev_r = 16'h0000;
    for (int i = 0; i < 37; i++) begin
      son = vecs[i].on; sl = vecs[i].l; sr = vecs[i].r;
      full_frame($sformatf("vec%0d", i));
      check($sformatf("vec%0d_word_l", i), cap_l, prev_l);
      check($sformatf("vec%0d_word_r", i), cap_r, prev_r);
      check($sformatf("vec%0d_muted", i), muted, vecs[i].exp_muted);
      check($sformatf("vec%0d_desync", i), desync, 0);
      if (i == 1) begin
        check("bck_rises_per_frame", bck_rises, 64);
        check("lrck_rise_phase", lrck_rise_ph, 256);
        check("lrck_fall_phase", lrck_fall_ph, 0);
      end
      prev_l = vecs[i].exp_l; prev_r = vecs[i].exp_r;
    end

    // phase jump forces desync and ramp-down; clean frame clears it
    son = 1'b1; sl = 16'h7FFF; sr = 16'h0000;
    for (int k = 0; k < 4; k++) full_frame("desync_pre");
    frame_begin();
    run_span(0, 100);
    do_tick(300);
    check("desync_set", desync, 1);
    run_span(301, 511);
    frame_end("desync_jump");
    check("desync_sticky", desync, 1);
    frame_begin();
    run_span(0, 510);
    check("desync_before_clear", desync, 1);
    do_tick(511);
    check("desync_cleared", desync, 0);
    frame_end("desync_clean");
    check("desync_word_g64", cap_l, 16'h1FFF);
    full_frame("desync_down");
    check("desync_word_g48", cap_l, 16'h17FF);
    full_frame("desync_up");
    check("desync_word_g32", cap_l, 16'h0FFF);
    frame_begin();
    run_span(0, 400);
    do_tick(511);
    check("desync_set_on_latch", desync, 1);
    frame_end("desync_latch_jump");
    full_frame("desync_latch_clean");
    check("desync_latch_cleared", desync, 0);

    // synchronous reset in the middle of a frame
    frame_begin();
    run_span(0, 199);
    rst = 1'b0; dac_clk = 1'b1; phase = 9'd200; next_sample = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; dac_clk = 1'b0;
    model_reset();
    check("rst_mid_bck", dac_bck, 0);
    check("rst_mid_lrck", dac_lrck, 0);
    check("rst_mid_sdo", dac_sdo, 0);
    check("rst_mid_muted", muted, 1);
    check("rst_mid_desync", desync, 0);
    last_bck = 1'b0; last_lrck = 1'b0;
    cap_l = 16'h0000; cap_r = 16'h0000;
    run_span(201, 511);
    frame_end("post_reset");
    check("post_reset_zero_l", cap_l, 0);
    check("post_reset_zero_r", cap_r, 0);
    full_frame("post_reset_next");

    // randomized frames: idle gaps, mid-frame snd_on flips, occasional jumps
    gaps_en = 1'b1; flip_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      sl = 16'($urandom); sr = 16'($urandom); son = 1'($urandom_range(0, 1));
      frame_begin();
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 400);
        b = $urandom_range(a + 2, 511);
        run_span(0, a);
        run_span(b, 511);
      end else begin
        run_span(0, 511);
      end
      frame_end($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
